// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window scheduler.
// Output dimensions are derived here so every file agrees on OW/OH.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StWrite,
    StDone
  } conv_state_e;

  localparam int unsigned DefImgW   = 8;
  localparam int unsigned DefImgH   = 8;
  localparam int unsigned DefK      = 3;
  localparam int unsigned DefMemLat = 1;
  localparam int unsigned DefAddrW  = 6;

  // Number of valid (no padding) kernel positions along one image axis.
  function automatic int unsigned out_dim(int unsigned img, int unsigned k);
    return img - k + 1;
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Control/memory-side signal bundle of the convolution scheduler.
// master = scheduler side, slave = environment (memory, MAC, write-back).
interface conv_sched_if #(
  parameter int unsigned ADDR_W = 6
);

  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        k_idx;
  logic              mac_clr;
  logic              mac_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    input  start, stall,
    output busy, done, rd_en, rd_addr, k_idx, mac_clr, mac_en, wr_en, wr_addr
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_en, rd_addr, k_idx, mac_clr, mac_en, wr_en, wr_addr
  );

endinterface

// File: rtl/conv_tap_delay.sv
// Fixed-depth shift register that lines tap control up with memory read data.
module conv_tap_delay #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [MEM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_LAT); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[MEM_LAT-1];

endmodule

// File: rtl/conv_sched.sv
// Sliding-window scheduler: walks every KxK window of an image, issuing tap
// reads, MAC controls aligned to read data, and one result write per window.
module conv_sched
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W   = DefImgW,
  parameter int unsigned IMG_H   = DefImgH,
  parameter int unsigned K       = DefK,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned MEM_LAT = DefMemLat
) (
  input logic          clk,
  input logic          rst,
  conv_sched_if.master bus
);

  localparam int unsigned OW    = out_dim(IMG_W, K);
  localparam int unsigned OH    = out_dim(IMG_H, K);
  localparam int unsigned KK    = K * K;
  localparam int unsigned WaitW = $clog2(MEM_LAT + 2);
  localparam int unsigned TapW  = 6;

  typedef logic [ADDR_W-1:0] addr_t;

  conv_state_e      state_q, state_d;
  addr_t            orow_q, orow_d, ocol_q, ocol_d;
  addr_t            r_q, r_d, c_q, c_d;
  logic [3:0]       tap_q, tap_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic             issue, last_tap, last_win;
  logic [TapW-1:0]  tap_in, tap_out;

  assign issue    = (state_q == StFetch) && !bus.stall;
  assign last_tap = (tap_q == 4'(KK - 1));
  assign last_win = (orow_q == addr_t'(OH - 1)) && (ocol_q == addr_t'(OW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      orow_q  <= '0;
      ocol_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      tap_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      r_q     <= r_d;
      c_q     <= c_d;
      tap_q   <= tap_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    r_d     = r_q;
    c_d     = c_q;
    tap_d   = tap_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFetch;
          orow_d  = '0;
          ocol_d  = '0;
          r_d     = '0;
          c_d     = '0;
          tap_d   = '0;
        end
      end
      StFetch: begin
        if (!bus.stall) begin
          if (last_tap) begin
            state_d = StWait;
            wait_d  = '0;
            r_d     = '0;
            c_d     = '0;
            tap_d   = '0;
          end else begin
            tap_d = tap_q + 4'd1;
            if (c_q == addr_t'(K - 1)) begin
              c_d = '0;
              r_d = r_q + addr_t'(1);
            end else begin
              c_d = c_q + addr_t'(1);
            end
          end
        end
      end
      // Fixed length so the last tap's data has landed in the MAC before write.
      StWait: begin
        wait_d = wait_q + WaitW'(1);
        if (wait_q == WaitW'(MEM_LAT)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!bus.stall) begin
          if (last_win) begin
            state_d = StDone;
            orow_d  = '0;
            ocol_d  = '0;
          end else begin
            state_d = StFetch;
            if (ocol_q == addr_t'(OW - 1)) begin
              ocol_d = '0;
              orow_d = orow_q + addr_t'(1);
            end else begin
              ocol_d = ocol_q + addr_t'(1);
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy    = (state_q == StFetch) || (state_q == StWait) || (state_q == StWrite);
  assign bus.done    = (state_q == StDone);
  assign bus.rd_en   = issue;
  assign bus.rd_addr = (state_q == StFetch) ?
                       (orow_q + r_q) * addr_t'(IMG_W) + ocol_q + c_q : '0;
  assign bus.wr_en   = (state_q == StWrite) && !bus.stall;
  assign bus.wr_addr = (state_q == StWrite) ? orow_q * addr_t'(OW) + ocol_q : '0;

  assign tap_in = {issue && (tap_q == 4'd0), issue, issue ? tap_q : 4'd0};

  conv_tap_delay #(
    .MEM_LAT (MEM_LAT),
    .WIDTH   (TapW)
  ) u_tap_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tap_in),
    .dout (tap_out)
  );

  assign {bus.mac_clr, bus.mac_en, bus.k_idx} = tap_out;

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: a window-walk model predicts timed events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_conv_sched;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int K       = 3;
  localparam int MEM_LAT = 1;
  localparam int ADDR_W  = 6;
  localparam int OW      = IMG_W - K + 1;
  localparam int OH      = IMG_H - K + 1;

  logic clk = 1'b0;
  logic rst;

  conv_sched_if #(.ADDR_W(ADDR_W)) bus ();
  conv_sched_if #(.ADDR_W(ADDR_W)) bus_s ();

  conv_sched #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .K       (K),
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  conv_sched #(
    .IMG_W   (3),
    .IMG_H   (3),
    .K       (3),
    .ADDR_W  (ADDR_W),
    .MEM_LAT (1)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit en; int addr;} rd_ev_t;
  typedef struct {int cyc; bit clr; int k;}   mac_ev_t;
  typedef struct {int cyc; int addr;}         wr_ev_t;

  rd_ev_t  rd_q[$];
  mac_ev_t mac_q[$];
  wr_ev_t  wr_q[$];
  bit      stall_pat[4096];
  int      done_cyc;
  int      cyc = 0;
  int      base = 0;
  int      mon_mode = 0;  // 0 off, 1 all outputs zero, 2 scoreboard
  int      n_chk = 0;
  int      n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endfunction

  function automatic void check_zero(string tag);
    check({tag, " busy"}, int'(bus.busy), 0);
    check({tag, " done"}, int'(bus.done), 0);
    check({tag, " rd_en"}, int'(bus.rd_en), 0);
    check({tag, " rd_addr"}, int'(bus.rd_addr), 0);
    check({tag, " mac_en"}, int'(bus.mac_en), 0);
    check({tag, " mac_clr"}, int'(bus.mac_clr), 0);
    check({tag, " k_idx"}, int'(bus.k_idx), 0);
    check({tag, " wr_en"}, int'(bus.wr_en), 0);
    check({tag, " wr_addr"}, int'(bus.wr_addr), 0);
  endfunction

  // Walks windows and taps in order; a stalled cycle delays the pending
  // fetch or write slot, WAIT always consumes MEM_LAT+1 cycles.
  task automatic build_model(input int stall_pct, input int fix_from, input int fix_len);
    int t;
    int a;
    rd_q.delete();
    mac_q.delete();
    wr_q.delete();
    for (int i = 0; i < 4096; i++) stall_pat[i] = (int'($urandom_range(99)) < stall_pct);
    for (int i = fix_from; i < fix_from + fix_len; i++) stall_pat[i] = 1'b1;
    t = 1;
    for (int orow = 0; orow < OH; orow++) begin
      for (int ocol = 0; ocol < OW; ocol++) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            a = (orow + r) * IMG_W + ocol + c;
            while (stall_pat[t]) begin
              rd_q.push_back('{t, 1'b0, a});
              t++;
            end
            rd_q.push_back('{t, 1'b1, a});
            mac_q.push_back('{t + MEM_LAT, (r == 0 && c == 0), r * K + c});
            t++;
          end
        end
        t += MEM_LAT + 1;
        while (stall_pat[t]) t++;
        wr_q.push_back('{t, orow * OW + ocol});
        t++;
      end
    end
    done_cyc = t;
  endtask

  always @(negedge clk) begin
    int rel;
    rel = cyc - base;
    if (mon_mode == 1) begin
      check_zero("idle");
    end else if (mon_mode == 2) begin
      if (rd_q.size() > 0 && rd_q[0].cyc == rel) begin
        check("rd_en", int'(bus.rd_en), int'(rd_q[0].en));
        check("rd_addr", int'(bus.rd_addr), rd_q[0].addr);
        rd_q.delete(0);
      end else begin
        check("rd_en off", int'(bus.rd_en), 0);
      end
      if (mac_q.size() > 0 && mac_q[0].cyc == rel) begin
        check("mac_en", int'(bus.mac_en), 1);
        check("mac_clr", int'(bus.mac_clr), int'(mac_q[0].clr));
        check("k_idx", int'(bus.k_idx), mac_q[0].k);
        mac_q.delete(0);
      end else begin
        check("mac_en off", int'(bus.mac_en), 0);
        check("mac_clr off", int'(bus.mac_clr), 0);
      end
      if (wr_q.size() > 0 && wr_q[0].cyc == rel) begin
        check("wr_en", int'(bus.wr_en), 1);
        check("wr_addr", int'(bus.wr_addr), wr_q[0].addr);
        wr_q.delete(0);
      end else begin
        check("wr_en off", int'(bus.wr_en), 0);
      end
      check("done", int'(bus.done), int'(rel == done_cyc));
      check("busy", int'(bus.busy), int'(rel >= 1 && rel < done_cyc));
    end
  end

  task automatic idle_cycles(input int n);
    @(posedge clk);
    #1;
    mon_mode = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cycle 0 carries the start pulse; extra_start re-pulses start mid-run,
  // abort_at asserts reset for one cycle, start_in_done pulses it in DONE.
  task automatic run(input int extra_start, input int abort_at, input bit start_in_done);
    @(posedge clk);
    #1;
    base      = cyc;
    bus.start = 1'b1;
    bus.stall = stall_pat[0];
    mon_mode  = 2;
    for (int t = 1; t <= done_cyc + 3; t++) begin
      @(posedge clk);
      #1;
      bus.start = (t == extra_start) || (start_in_done && t == done_cyc);
      bus.stall = stall_pat[t];
      if (t == abort_at) begin
        mon_mode = 0;
        rst      = 1'b1;
        #1;
        check_zero("abort");
        rd_q.delete();
        mac_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("rd events left", rd_q.size(), 0);
    check("mac events left", mac_q.size(), 0);
    check("wr events left", wr_q.size(), 0);
    idle_cycles(4);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stall   = 1'b0;
    bus_s.start = 1'b0;
    bus_s.stall = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    mon_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(5);

    // Plain default run, then a 3-cycle stall while tap 3 (addr 8) is pending.
    build_model(0, 0, 0);
    run(-1, -1, 1'b0);
    build_model(0, 4, 3);
    run(-1, -1, 1'b0);

    // Start ignored while busy, reset mid-run, then a clean restart.
    build_model(0, 0, 0);
    run(20, 50, 1'b0);
    build_model(0, 0, 0);
    run(-1, -1, 1'b1);

    for (int i = 0; i < 3; i++) begin
      build_model(15, 0, 0);
      run(-1, -1, 1'b0);
    end

    // Single-window image.
    @(posedge clk);
    #1;
    base        = cyc;
    bus_s.start = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      check("small rd_en", int'(bus_s.rd_en), int'(t >= 1 && t <= 9));
      check("small wr_en", int'(bus_s.wr_en), int'(t == 12));
      if (t == 12) check("small wr_addr", int'(bus_s.wr_addr), 0);
      check("small done", int'(bus_s.done), int'(t == 13));
      check("small busy", int'(bus_s.busy), int'(t >= 1 && t <= 12));
      @(posedge clk);
      #1;
      bus_s.start = 1'b0;
    end

    mon_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter IMG_W, default 8, input image width in pixels.
REQ-002 Parameter IMG_H, default 8, input image height in pixels.
REQ-003 Parameter K, default 3, square kernel size. IMG_W and IMG_H SHALL each be >= K.
REQ-004 Parameter ADDR_W, default 6, address width; 2^ADDR_W SHALL be >= IMG_W*IMG_H.
REQ-005 Parameter MEM_LAT, default 1, image-memory read latency in cycles (>= 1).
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  run request, sampled in IDLE only.
REQ-009 stall  in  1  hold request from downstream; freezes FETCH and WRITE.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse after the final result write.
REQ-012 rd_en  out  1  image-memory read strobe.
REQ-013 rd_addr  out  ADDR_W  image read address = (orow+r)*IMG_W + ocol + c.
REQ-014 k_idx  out  4  kernel tap index r*K+c, aligned with mac_en.
REQ-015 mac_clr  out  1  MAC accumulator clear, aligned with the first tap's returned data.
REQ-016 mac_en  out  1  MAC accumulate enable, aligned with each tap's returned data.
REQ-017 wr_en  out  1  output-pixel write strobe.
REQ-018 wr_addr  out  ADDR_W  output pixel index orow*OW + ocol, where OW = IMG_W-K+1.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, WAIT, WRITE and DONE.
REQ-020 IDLE -> FETCH on start=1; the window counter SHALL be set to orow=0, ocol=0.
REQ-021 FETCH SHALL issue one tap per non-stalled cycle in row-major order (r, then c), with rd_en=1, for K*K taps, then go to WAIT.
REQ-022 WAIT SHALL last exactly MEM_LAT+1 cycles regardless of stall, then go to WRITE.
REQ-023 WRITE SHALL assert wr_en for one non-stalled cycle, then advance the window: ocol+1, wrapping to 0 with orow+1 at ocol = OW-1.
REQ-024 After WRITE, the FSM SHALL return to FETCH, or go to DONE if the last window (orow=OH-1, ocol=OW-1, OH=IMG_H-K+1) was written.
REQ-025 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-026 mac_clr, mac_en and k_idx SHALL equal the FETCH-stage values delayed by exactly MEM_LAT cycles.
REQ-027 mac_clr SHALL be 1 only for tap 0.
REQ-028 While stall=1 in FETCH or WRITE: rd_en=0 and wr_en=0, and the tap and window counters SHALL hold.
REQ-029 A start while busy, or in DONE, SHALL be ignored.
REQ-030 Unstalled cycles per window SHALL be K*K + MEM_LAT + 2; the default configuration SHALL take 36 windows x 12 = 432 cycles.
REQ-031 Address arithmetic SHALL be unsigned at ADDR_W bits with no wrap inside a legal image.

Reset
REQ-032 On rst=1, the FSM SHALL go to IDLE immediately, all counters and the delay line SHALL clear, and every output SHALL be 0.
REQ-033 Reset asserted mid-run SHALL abort the run, with no further wr_en or done; the next start SHALL begin at window 0.

Structure
REQ-034 Package conv_pkg SHALL hold the state encoding, default IMG_W/IMG_H/K/MEM_LAT, and OW/OH derivation constants.
REQ-035 Sub-module conv_tap_delay SHALL implement the MEM_LAT-deep shift register for {mac_clr, mac_en, k_idx}, with asynchronous reset.

Verification
REQ-036 Reset: rst=1 for 4 cycles, then release -> all outputs 0 and busy=0 until start.
REQ-037 Default run, start pulse at cycle 0 -> first 9 rd_addr values 0,1,2,8,9,10,16,17,18; mac_clr at cycle 2; wr_en with wr_addr=0 at cycle 12; done at cycle 433.
REQ-038 Row wrap -> window 5 first rd_addr=5; window 6 first rd_addr=8, wr_addr=6; last tap of window 35 reads addr 63, with wr_addr=35.
REQ-039 stall=1 for 3 cycles after tap 3 of window 0 -> rd_addr holds 8 with rd_en=0; tap 4 reads addr 9; done is delayed by exactly 3 cycles.
REQ-040 start asserted at cycle 20 while busy -> ignored; rst pulse at cycle 50 -> outputs 0 immediately; new start -> full 432-cycle run from window 0.
REQ-041 IMG_W=IMG_H=K=3 -> a single window, wr_addr=0 at cycle 12, done at cycle 13.
